vga_line_capture: RTL and testbench
===================================

// Module: vga_line_capture
// PURPOSE
//  Receive end of the on-fabric 3-bit VGA output: samples hsync/vsync/RGB pins fed back from the
//  video generator (or an external source), measures line and frame timing, declares lock, and
//  captures one selected visible line into a BRAM (32 x 32-bit words) for readback/self-check.
//  Sits between io_in pins and a bramN_wr_* port; controlled by a software/test strobe.
// PARAMETERS
//  H_TOTAL    320  expected clk cycles between hsync falling edges
//  V_TOTAL    525  expected lines between vsync falling edges
//  H_OFFSET   58   cycles from detected hsync fall to first visible pixel sample
//  V_OFFSET   35   hsync falls after vsync fall preceding visible line 0
//  H_ACTIVE   256  visible pixels captured per line (multiple of 8)
//  LOCK_LINES 16   consecutive good lines required for lock
// PORTS
//  clk          in   1   system clock (same rate as pixel clock)
//  rst_n        in   1   asynchronous active-low reset
//  vga_hsync    in   1   hsync, active low, asynchronous to sampling
//  vga_vsync    in   1   vsync, active low
//  vga_rgb      in   3   {b,g,r} pixel
//  cap_start    in   1   one-cycle strobe: arm a capture
//  cap_line     in   9   visible line index to capture (0..479)
//  cap_busy     out  1   capture armed or in progress
//  cap_done     out  1   one-cycle pulse: line fully written
//  cap_err      out  1   one-cycle pulse: capture aborted (lock lost)
//  locked       out  1   timing lock
//  h_period     out  10  last measured hsync period (saturates 1023)
//  v_lines      out  10  last measured lines per frame (saturates 1023)
//  bram_wr_en   out  1   BRAM write strobe
//  bram_wr_addr out  8   word address 0..H_ACTIVE/8-1
//  bram_wr_data out  32  packed pixels
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; counters 0; h_period/v_lines 0.
//  Input path: 2-FF synchroniser on all 5 inputs, then 1 register for edge detect; fall = prev&~cur.
//  All timing below is relative to the synchronised signals (fixed 3-cycle input latency).
//  h counter: cleared to 1 on hsync fall, else +1 saturating at 1023; on fall h_period <= count.
//  Line counter: +1 per hsync fall, saturating; on vsync fall v_lines <= count, counter <= 0.
//  Lock: good line = hsync fall with count==H_TOTAL; good_cnt +1 (sat LOCK_LINES), bad line -> 0.
//   locked = good_cnt==LOCK_LINES; cleared immediately on bad line, on vsync fall with
//   line count != V_TOTAL (skip check on first vsync after reset), or h counter reaching 2*H_TOTAL.
//  FSM: IDLE -cap_start & locked-> ARMED; cap_start while unlocked: cap_err pulse, stay IDLE.
//   ARMED -vsync fall-> WAIT_LINE. WAIT_LINE: on hsync fall number V_OFFSET+cap_line -> CAPTURE.
//   CAPTURE: sample pixel p (0..H_ACTIVE-1) at h count H_OFFSET+p; pixel p placed in bits
//   [3(p%8)+2 : 3(p%8)] of word p/8, bits [31:24]=0; write strobed the cycle after pixel p%8==7
//   sampled, addr=p/8. After last word -> IDLE with cap_done pulse same cycle as final write.
//  cap_busy=1 in ARMED/WAIT_LINE/CAPTURE. cap_start while busy ignored.
//  Lock loss in ARMED/WAIT_LINE/CAPTURE: abort to IDLE, cap_err pulse, no further writes.
//  cap_line sampled on accepted cap_start; values >=480 never reach CAPTURE before next vsync:
//   vsync fall in WAIT_LINE/CAPTURE -> abort with cap_err.
//  Simultaneous hsync & vsync fall: vsync update first (line counter 0), then hsync counts as 1.
//  bram_wr_en max 1 cycle per word; addr/data stable only while wr_en=1.
// TESTING
//  Drive ideal 320x525 timing 20 lines -> locked rises after 16th good hsync fall; h_period=320.
//  Locked, cap_line=0, pixel p colour=p%8 -> 32 writes addr 0..31, each data 0x00FAC688, cap_done.
//  Locked, one line of 319 cycles mid-capture -> locked=0, cap_err pulse, writes stop.
//  cap_start while unlocked -> cap_err next cycle, cap_busy stays 0, no writes.
//  Frame of 524 lines -> v_lines=524, locked drops at vsync fall; recovers after 16 good lines.
//  Assert rst_n low mid-CAPTURE -> all outputs 0 asynchronously, no write after release.

Source files
------------

// File: rtl/vga_line_capture_if.sv
// ---------------------------------------------------------------------------
// vga_line_capture_if
//   BRAM write port carried from the line-capture block to a 32 x 32-bit
//   line buffer.
//   master : drives bram_wr_en / bram_wr_addr / bram_wr_data (capture block)
//   slave  : receives the same signals (BRAM or a monitor)
// ---------------------------------------------------------------------------
interface vga_line_capture_if;
    logic        bram_wr_en;
    logic [7:0]  bram_wr_addr;
    logic [31:0] bram_wr_data;

    modport master (output bram_wr_en, bram_wr_addr, bram_wr_data);
    modport slave  (input  bram_wr_en, bram_wr_addr, bram_wr_data);
endinterface

// File: rtl/vga_line_capture.sv
// ---------------------------------------------------------------------------
// vga_line_capture
//   Receive side of the 3-bit VGA output. Synchronises hsync/vsync/RGB,
//   measures line and frame timing, declares lock, and captures one selected
//   visible line (8 pixels per 32-bit word) into a BRAM.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   vga_hsync_i/_vsync_i active-low syncs (asynchronous)
//   vga_rgb_i           {b,g,r} pixel
//   cap_start_i         one-cycle strobe arming a capture of line cap_line_i
//   cap_busy_o          capture armed or in progress
//   cap_done_o          pulse with the final BRAM write
//   cap_err_o           pulse: start while unlocked, or capture aborted
//   locked_o            timing lock
//   h_period_o          last hsync period in clocks (saturating)
//   v_lines_o           last lines-per-frame count (saturating)
//   bram                BRAM write port (master)
// ---------------------------------------------------------------------------
module vga_line_capture #(
    parameter int H_TOTAL    = 320,
    parameter int V_TOTAL    = 525,
    parameter int H_OFFSET   = 58,
    parameter int V_OFFSET   = 35,
    parameter int H_ACTIVE   = 256,
    parameter int LOCK_LINES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vga_hsync_i,
    input  logic               vga_vsync_i,
    input  logic [2:0]         vga_rgb_i,
    input  logic               cap_start_i,
    input  logic [8:0]         cap_line_i,
    output logic               cap_busy_o,
    output logic               cap_done_o,
    output logic               cap_err_o,
    output logic               locked_o,
    output logic [9:0]         h_period_o,
    output logic [9:0]         v_lines_o,
    vga_line_capture_if.master bram
);
    localparam int PIX_W = $clog2(H_ACTIVE);
    localparam int GW    = $clog2(LOCK_LINES + 1);

    localparam logic [9:0]       CNT_MAX  = 10'd1023;
    localparam logic [9:0]       H_TOT_C  = 10'(H_TOTAL);
    localparam logic [9:0]       H_TO_C   = 10'(2 * H_TOTAL);
    localparam logic [9:0]       V_TOT_C  = 10'(V_TOTAL);
    localparam logic [9:0]       H_OFF_C  = 10'(H_OFFSET);
    localparam logic [9:0]       V_OFF_C  = 10'(V_OFFSET);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(H_ACTIVE - 1);
    localparam logic [GW-1:0]    LOCK_C   = GW'(LOCK_LINES);

    typedef enum logic [1:0] {IDLE, ARMED, WAIT_LINE, CAPTURE} state_t;

    // Input path: {rgb, vsync, hsync} through two sync flops, then one more
    // register on the syncs for falling-edge detection.
    logic [4:0] sync1_q, sync2_q;
    logic [1:0] prev_q;
    logic       h_fall, v_fall;
    logic [2:0] rgb_s;

    assign h_fall = prev_q[0] & ~sync2_q[0];
    assign v_fall = prev_q[1] & ~sync2_q[1];
    assign rgb_s  = sync2_q[4:2];

    logic [9:0]    hcnt_q, hcnt_d, lcnt_q, lcnt_d;
    logic [9:0]    h_period_q, v_lines_q;
    logic [GW-1:0] good_q, good_d;
    logic          locked_q, locked_d;
    logic          seen_v_q;

    always_comb begin
        hcnt_d = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1;
        if (h_fall) hcnt_d = 10'd1;

        // vsync clears first, so a coincident hsync fall counts as line 1
        lcnt_d = lcnt_q;
        if (v_fall) lcnt_d = '0;
        if (h_fall && lcnt_d != CNT_MAX) lcnt_d = lcnt_d + 10'd1;

        good_d = good_q;
        if (h_fall)
            good_d = (hcnt_q != H_TOT_C) ? '0 :
                     (good_q == LOCK_C)  ? good_q : good_q + GW'(1);
        // The first vsync after reset follows an unknown partial frame.
        if (v_fall && seen_v_q && lcnt_q != V_TOT_C) good_d = '0;
        if (hcnt_q >= H_TO_C) good_d = '0;   // hsync has gone missing
        locked_d = (good_d == LOCK_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            hcnt_q     <= '0;
            lcnt_q     <= '0;
            good_q     <= '0;
            locked_q   <= 1'b0;
            seen_v_q   <= 1'b0;
            h_period_q <= '0;
            v_lines_q  <= '0;
        end else begin
            sync1_q  <= {vga_rgb_i, vga_vsync_i, vga_hsync_i};
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q[1:0];
            hcnt_q   <= hcnt_d;
            lcnt_q   <= lcnt_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            if (h_fall) h_period_q <= hcnt_q;
            if (v_fall) begin
                v_lines_q <= lcnt_q;
                seen_v_q  <= 1'b1;
            end
        end
    end

    // Capture FSM. Aborts use locked_d so cap_err lines up with locked falling.
    state_t           state_q;
    logic [9:0]       tgt_q;
    logic [PIX_W-1:0] pix_q;
    logic [23:0]      word_q, word_nx;
    logic             done_q, err_q, wr_en_q;
    logic [7:0]       wr_addr_q;
    logic [31:0]      wr_data_q;

    always_comb begin
        word_nx = word_q;
        word_nx[3 * pix_q[2:0] +: 3] = rgb_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            pix_q     <= '0;
            word_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: if (cap_start_i) begin
                    if (locked_q) begin
                        state_q <= ARMED;
                        tgt_q   <= V_OFF_C + 10'(cap_line_i);
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!locked_d) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else if (v_fall) begin
                        state_q <= WAIT_LINE;
                    end
                end
                WAIT_LINE: begin
                    // a vsync here means the line index was past the frame
                    if (!locked_d || v_fall) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else if (h_fall && lcnt_d == tgt_q) begin
                        state_q <= CAPTURE;
                        pix_q   <= '0;
                    end
                end
                CAPTURE: begin
                    if (!locked_d || v_fall) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else if (hcnt_q == H_OFF_C + 10'(pix_q)) begin
                        word_q <= word_nx;
                        pix_q  <= pix_q + PIX_W'(1);
                        if (pix_q[2:0] == 3'd7) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= 8'(pix_q >> 3);
                            wr_data_q <= {8'd0, word_nx};
                        end
                        if (pix_q == PIX_LAST) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cap_busy_o        = (state_q != IDLE);
    assign cap_done_o        = done_q;
    assign cap_err_o         = err_q;
    assign locked_o          = locked_q;
    assign h_period_o        = h_period_q;
    assign v_lines_o         = v_lines_q;
    assign bram.bram_wr_en   = wr_en_q;
    assign bram.bram_wr_addr = wr_addr_q;
    assign bram.bram_wr_data = wr_data_q;
endmodule

// File: tb/tb_vga_line_capture.sv
// Bench for vga_line_capture. Horizontal timing is the nominal 320/58/256;
// the frame is shortened to 24 lines (V_OFFSET 3) to keep the run short.
module tb_vga_line_capture;
    localparam int HT    = 320;
    localparam int VT    = 24;
    localparam int VO    = 3;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hs, vs;
    logic [2:0] rgb;
    logic       cap_start;
    logic [8:0] cap_line;
    logic       cap_busy, cap_done, cap_err, locked;
    logic [9:0] h_period, v_lines;

    vga_line_capture_if bus();

    vga_line_capture #(.H_TOTAL(HT), .V_TOTAL(VT), .H_OFFSET(58), .V_OFFSET(VO),
                       .H_ACTIVE(256), .LOCK_LINES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_hsync_i(hs), .vga_vsync_i(vs), .vga_rgb_i(rgb),
        .cap_start_i(cap_start), .cap_line_i(cap_line),
        .cap_busy_o(cap_busy), .cap_done_o(cap_done), .cap_err_o(cap_err),
        .locked_o(locked), .h_period_o(h_period), .v_lines_o(v_lines),
        .bram(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wr_seen = 0;

    // Expected events: kind 0 = BRAM write, 1 = cap_done, 2 = cap_err
    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] data;
    } ev_t;
    ev_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_words(input int n, input logic [31:0] data, input int tail);
        for (int w = 0; w < n; w++) push(0, 8'(w), data);
        push(tail, 8'd0, 32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bram_wr_en) begin
                ev_t e;
                wr_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%h, none expected",
                             bus.bram_wr_addr, bus.bram_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != 0 || e.addr != bus.bram_wr_addr || e.data != bus.bram_wr_data) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%h, expected kind=%0d addr=%0d data=%h",
                                 bus.bram_wr_addr, bus.bram_wr_data, e.kind, e.addr, e.data);
                    end
                end
            end
            if (cap_done) begin
                ev_t e;
                checks++;
                if (exp_q.size() == 0 || !bus.bram_wr_en) begin
                    errors++;
                    $display("FAIL cap_done: got pulse (wr_en=%0d), expected with final write",
                             bus.bram_wr_en);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != 1) begin
                        errors++;
                        $display("FAIL cap_done: got done, expected event kind %0d", e.kind);
                    end
                end
            end
            if (cap_err) begin
                ev_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL cap_err: got pulse, none expected");
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != 2) begin
                        errors++;
                        $display("FAIL cap_err: got err, expected event kind %0d", e.kind);
                    end
                end
            end
        end
    end

    // Video source: line y of a frame, pixel column x; hsync low for x<38,
    // vsync low for lines 0..1, so both fall together at the start of line 0.
    // mode 0: pixel p = p%8; mode 1: whole line coloured y%8.
    int gen_en = 0, gen_lines = 0, gen_y = 0, gen_frame = 0;
    int short_len = 0, next_frame_len = VT, mode = 0;

    initial begin
        hs = 1'b1; vs = 1'b1; rgb = 3'd0;
        wait (gen_en != 0);
        forever begin
            int fl;
            fl = next_frame_len;
            next_frame_len = VT;
            for (int y = 0; y < fl; y++) begin
                int len;
                len = HT;
                if (short_len != 0) begin
                    len = short_len;
                    short_len = 0;
                end
                gen_y = y;
                gen_lines++;
                for (int x = 0; x < len; x++) begin
                    @(negedge clk);
                    hs = (x < 38) ? 1'b0 : 1'b1;
                    vs = (y < 2) ? 1'b0 : 1'b1;
                    if (x >= 58 && x < 58 + 256)
                        rgb = (mode == 0) ? 3'((x - 58) % 8) : 3'(y % 8);
                    else
                        rgb = 3'd0;
                end
            end
            gen_frame++;
        end
    end

    task automatic start_cap(input logic [8:0] line);
        @(negedge clk);
        cap_line  = line;
        cap_start = 1'b1;
        @(negedge clk);
        cap_start = 1'b0;
        chk("busy_after_start", cap_busy, 1);
    endtask

    task automatic wait_locked(input int bound);
        int i;
        i = 0;
        while (!locked && i < bound) begin @(negedge clk); i++; end
        chk("lock_wait", locked, 1);
    endtask

    task automatic wait_q_empty(input string name, input int bound);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < bound) begin @(negedge clk); i++; end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_frame(input int target, input int bound);
        int i;
        i = 0;
        while (gen_frame < target && i < bound) begin @(negedge clk); i++; end
        chk("frame_wait", gen_frame, target);
    endtask

    task automatic wait_lines(input int target, input int bound);
        int i;
        i = 0;
        while (gen_lines < target && i < bound) begin @(negedge clk); i++; end
        chk("line_wait", gen_lines, target);
    endtask

    initial begin : watchdog
        #(95000 * 10);
        $display("FAIL watchdog: run exceeded 95000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int f0, g0, w0;
        rst_n = 1'b0; cap_start = 1'b0; cap_line = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", cap_busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_hper", h_period, 0);
        chk("rst_vlines", v_lines, 0);
        chk("rst_wr_en", bus.bram_wr_en, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // start while unlocked: error pulse, never busy
        push(2, 8'd0, 32'd0);
        cap_start = 1'b1;
        @(negedge clk);
        cap_start = 1'b0;
        chk("unlk_err", cap_err, 1);
        chk("unlk_busy", cap_busy, 0);
        @(negedge clk);
        chk("unlk_err_pulse", cap_err, 0);
        chk("unlk_busy2", cap_busy, 0);

        // lock: first fall is bad, 16 good falls follow
        gen_en = 1;
        wait_locked(30 * HT);
        chk("lock_after_17_falls", gen_lines, 17);
        chk("hper_320", h_period, 320);

        // capture line 0, pixel p = p%8
        push_words(32, 32'h00FAC688, 1);
        start_cap(9'd0);
        wait_q_empty("capA_complete", 3 * FRAME);
        chk("vlines_24", v_lines, VT);

        // capture line 2 with line colour = line number -> frame line 4
        mode = 1;
        push_words(32, 32'h00924924, 1);
        start_cap(9'd2);
        wait_q_empty("capB_complete", 3 * FRAME);
        mode = 0;

        // one 319-cycle line drops lock
        g0 = gen_lines;
        short_len = 319;
        wait_lines(g0 + 2, 3 * HT);
        repeat (10) @(negedge clk);
        chk("hper_319", h_period, 319);
        chk("unlock_319", locked, 0);
        wait_locked(20 * HT);

        // early hsync inside the captured line: 11 words then abort
        push_words(11, 32'h00FAC688, 2);
        start_cap(9'd0);
        f0 = gen_frame;
        wait_frame(f0 + 1, FRAME + HT);
        while (gen_y != 1) @(negedge clk);
        short_len = 150;
        wait_q_empty("abort_seq", 3 * HT);
        chk("abort_unlocked", locked, 0);
        chk("hper_150", h_period, 150);
        chk("abort_busy", cap_busy, 0);

        // a frame of VT-1 lines
        wait_locked(20 * HT);
        next_frame_len = VT - 1;
        f0 = gen_frame;
        wait_frame(f0 + 1, FRAME);
        repeat (20) @(negedge clk);
        chk("vlines_good", v_lines, VT);
        chk("locked_before_short_frame", locked, 1);
        wait_frame(f0 + 2, FRAME);
        repeat (20) @(negedge clk);
        chk("vlines_short", v_lines, VT - 1);
        chk("unlock_short_frame", locked, 0);
        wait_locked(20 * HT);
        chk("relock_line", gen_y, 16);

        // line index beyond the frame: aborted at the next vsync
        push(2, 8'd0, 32'd0);
        start_cap(9'd480);
        wait_q_empty("line480_err", 3 * FRAME);
        chk("line480_busy", cap_busy, 0);
        chk("line480_locked", locked, 1);

        // asynchronous reset mid-capture
        push_words(32, 32'h00FAC688, 1);
        start_cap(9'd0);
        begin
            int i;
            i = 0;
            while (exp_q.size() > 28 && i < 3 * FRAME) begin @(negedge clk); i++; end
        end
        chk("capture_running", cap_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", cap_busy, 0);
        chk("arst_done", cap_done, 0);
        chk("arst_err", cap_err, 0);
        chk("arst_locked", locked, 0);
        chk("arst_hper", h_period, 0);
        chk("arst_vlines", v_lines, 0);
        chk("arst_wr_en", bus.bram_wr_en, 0);
        chk("arst_wr_addr", bus.bram_wr_addr, 0);
        chk("arst_wr_data", bus.bram_wr_data, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        w0 = wr_seen;
        repeat (2 * HT) @(negedge clk);
        chk("post_rst_writes", wr_seen - w0, 0);
        chk("post_rst_busy", cap_busy, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
